// File: rtl/decoder_3_to_8_if.sv
// Select/decode bus for decoder_3_to_8: select code and enable in,
// decoded line word out.
interface decoder_3_to_8_if;
  logic [2:0] w;
  logic       en;
  logic [7:0] out;

  modport master (
    output w,
    output en,
    input  out
  );

  modport slave (
    input  w,
    input  en,
    output out
  );
endinterface

// File: rtl/decoder_3_to_8.sv
// Registered 3-to-8 one-hot decoder with enable and selectable output polarity.
// Reset asynchronously forces every line to its inactive level.
module decoder_3_to_8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  decoder_3_to_8_if.slave   bus
);

  localparam logic [7:0] INACTIVE = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] hot_d;
  logic [7:0] out_d;
  logic [7:0] out_q;

  // Explicit case so an unknown select falls to the all-off default
  // rather than smearing X across several lines.
  always_comb begin
    hot_d = '0;
    if (bus.en) begin
      case (bus.w)
        3'd0:    hot_d = 8'h01;
        3'd1:    hot_d = 8'h02;
        3'd2:    hot_d = 8'h04;
        3'd3:    hot_d = 8'h08;
        3'd4:    hot_d = 8'h10;
        3'd5:    hot_d = 8'h20;
        3'd6:    hot_d = 8'h40;
        3'd7:    hot_d = 8'h80;
        default: hot_d = '0;
      endcase
    end
    out_d = OUT_ACTIVE_LOW ? ~hot_d : hot_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= INACTIVE;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_decoder_3_to_8.sv
// Directed and randomised checks of decoder_3_to_8 in both output polarities.
module tb_decoder_3_to_8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decoder_3_to_8_if ah_if ();
  decoder_3_to_8_if al_if ();

  decoder_3_to_8 #(.OUT_ACTIVE_LOW(1'b0)) dut_ah (
    .clk (clk),
    .rst (rst),
    .bus (ah_if)
  );

  decoder_3_to_8 #(.OUT_ACTIVE_LOW(1'b1)) dut_al (
    .clk (clk),
    .rst (rst),
    .bus (al_if)
  );

  logic [7:0] onehot_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                 8'h10, 8'h20, 8'h40, 8'h80};

  task automatic drive(input logic [2:0] w, input logic en);
    ah_if.w  = w;
    ah_if.en = en;
    al_if.w  = w;
    al_if.en = en;
  endtask

  task automatic step(input logic [2:0] w, input logic en);
    @(negedge clk);
    drive(w, en);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(3'd0, 1'b0);
    #12;
    checks++;
    if (ah_if.out !== 8'h00) begin
      errors++;
      $display("FAIL reset_ah: got %h expected 00", ah_if.out);
    end
    checks++;
    if (al_if.out !== 8'hFF) begin
      errors++;
      $display("FAIL reset_al: got %h expected FF", al_if.out);
    end
    // Edge while reset is held must not decode.
    drive(3'd3, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (ah_if.out !== 8'h00) begin
      errors++;
      $display("FAIL reset_held_edge: got %h expected 00", ah_if.out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ah_if.out !== 8'h08) begin
      errors++;
      $display("FAIL first_decode: got %h expected 08", ah_if.out);
    end
  endtask

  task automatic test_sweep_enabled();
    for (int i = 0; i < 8; i++) begin
      step(3'(i), 1'b1);
      checks++;
      if (ah_if.out !== onehot_tbl[i]) begin
        errors++;
        $display("FAIL sweep_en w=%0d: got %h expected %h", i, ah_if.out, onehot_tbl[i]);
      end
    end
  endtask

  task automatic test_sweep_disabled();
    for (int i = 0; i < 8; i++) begin
      step(3'(i), 1'b0);
      checks++;
      if (ah_if.out !== 8'h00) begin
        errors++;
        $display("FAIL sweep_dis w=%0d: got %h expected 00", i, ah_if.out);
      end
    end
  endtask

  task automatic test_en_toggle();
    logic       en_seq  [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] exp_seq [3] = '{8'h20, 8'h00, 8'h20};
    logic [7:0] prev;
    prev = ah_if.out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(3'd5, en_seq[i]);
      #1;
      checks++;
      if (ah_if.out !== prev) begin
        errors++;
        $display("FAIL en_no_comb step%0d: got %h expected %h", i, ah_if.out, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ah_if.out !== exp_seq[i]) begin
        errors++;
        $display("FAIL en_toggle step%0d: got %h expected %h", i, ah_if.out, exp_seq[i]);
      end
      prev = exp_seq[i];
    end
  endtask

  task automatic test_async_reset();
    step(3'd7, 1'b1);
    checks++;
    if (ah_if.out !== 8'h80) begin
      errors++;
      $display("FAIL pre_rst: got %h expected 80", ah_if.out);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ah_if.out !== 8'h00) begin
      errors++;
      $display("FAIL async_rst_ah: got %h expected 00", ah_if.out);
    end
    checks++;
    if (al_if.out !== 8'hFF) begin
      errors++;
      $display("FAIL async_rst_al: got %h expected FF", al_if.out);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (ah_if.out !== 8'h00) begin
      errors++;
      $display("FAIL rst_release_hold: got %h expected 00", ah_if.out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ah_if.out !== 8'h80) begin
      errors++;
      $display("FAIL post_rst: got %h expected 80", ah_if.out);
    end
  endtask

  task automatic test_active_low();
    step(3'd2, 1'b1);
    checks++;
    if (al_if.out !== 8'hFB) begin
      errors++;
      $display("FAIL al_w2: got %h expected FB", al_if.out);
    end
    step(3'd2, 1'b0);
    checks++;
    if (al_if.out !== 8'hFF) begin
      errors++;
      $display("FAIL al_en0: got %h expected FF", al_if.out);
    end
    step(3'd6, 1'b1);
    checks++;
    if (al_if.out !== 8'hBF) begin
      errors++;
      $display("FAIL al_w6: got %h expected BF", al_if.out);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (al_if.out !== 8'hFF) begin
      errors++;
      $display("FAIL al_rst: got %h expected FF", al_if.out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] w;
    logic       en;
    logic [7:0] exp;
    for (int i = 0; i < 1000; i++) begin
      w  = 3'($urandom_range(0, 7));
      en = 1'($urandom_range(0, 1));
      exp = en ? onehot_tbl[w] : 8'h00;
      step(w, en);
      checks++;
      if (ah_if.out !== exp) begin
        errors++;
        $display("FAIL rand_ah #%0d w=%0d en=%0b: got %h expected %h", i, w, en, ah_if.out, exp);
      end
      checks++;
      if (al_if.out !== ~exp) begin
        errors++;
        $display("FAIL rand_al #%0d w=%0d en=%0b: got %h expected %h", i, w, en, al_if.out, ~exp);
      end
      checks++;
      if ($countones(ah_if.out) != 32'(en)) begin
        errors++;
        $display("FAIL rand_onehot #%0d: got %0d ones expected %0d", i, $countones(ah_if.out), en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep_enabled();
    test_sweep_disabled();
    test_en_toggle();
    test_async_reset();
    test_active_low();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
